// File: rtl/vtage_pkg.sv
// Shared types and hash helpers for the VTAGE front-stage index/tag generation.
// Folds and hashes return 32-bit values; callers truncate to their own widths.
package vtage_pkg;

  localparam int NUM_PRED_DEF  = 2;
  localparam int TAG_WIDTH_DEF = 8;
  localparam int HIST_LEN_DEF  = 16;
  localparam int HIST_MAX      = 64;

  typedef struct packed {
    logic [31:0] index;
    logic [31:0] tag;
    logic        valid;
  } fw_req_t;

  // XOR of consecutive w-bit chunks of the low hist_len bits, LSB first.
  function automatic logic [31:0] vtage_fold(input logic [HIST_MAX-1:0] h,
                                             input int hist_len, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < HIST_MAX; i++) begin
      if (i < hist_len) r[i % w] = r[i % w] ^ h[i];
    end
    return r;
  endfunction

  function automatic logic [31:0] vtage_hash_index(input logic [31:0] pc,
                                                   input logic [HIST_MAX-1:0] h,
                                                   input int hist_len, input int iw);
    return (pc >> 2) ^ vtage_fold(h, hist_len, iw);
  endfunction

  function automatic logic [31:0] vtage_hash_tag(input logic [31:0] pc,
                                                 input logic [HIST_MAX-1:0] h,
                                                 input int hist_len, input int iw,
                                                 input int tw);
    return (pc >> (2 + iw)) ^ vtage_fold(h, hist_len, tw)
           ^ (vtage_fold(h, hist_len, tw - 1) << 1);
  endfunction

endpackage

// File: rtl/vtage_ghr.sv
// Global branch history register: ordered multi-slot shift-in with restore override.
module vtage_ghr
  import vtage_pkg::*;
#(
  parameter int P_NUM_PRED = NUM_PRED_DEF,
  parameter int P_HIST_LEN = HIST_LEN_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [P_NUM_PRED-1:0] br_valid_i,
  input  logic [P_NUM_PRED-1:0] br_taken_i,
  input  logic                  restore_valid_i,
  input  logic [P_HIST_LEN-1:0] restore_hist_i,
  output logic [P_HIST_LEN-1:0] ghr_o
);

  logic [P_HIST_LEN-1:0] ghr_q, ghr_d;

  // Lower slots shift in first, so the highest valid slot ends up in bit 0.
  always_comb begin
    ghr_d = ghr_q;
    for (int s = 0; s < P_NUM_PRED; s++) begin
      if (br_valid_i[s]) ghr_d = {ghr_d[P_HIST_LEN-2:0], br_taken_i[s]};
    end
    if (restore_valid_i) ghr_d = restore_hist_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end

  assign ghr_o = ghr_q;

endmodule

// File: rtl/vtage_index_gen.sv
// VTAGE bank front stage: hashes request PCs with folded GHR into a registered
// forward-lookup bus, and exports the GHR snapshot used for that lookup.
module vtage_index_gen
  import vtage_pkg::*;
#(
  parameter int P_BANK         = 1,
  parameter int P_NUM_PRED     = NUM_PRED_DEF,
  parameter int P_NUM_ENTRIES  = 256,
  parameter int P_TAG_WIDTH    = TAG_WIDTH_DEF,
  parameter int P_HIST_LEN     = HIST_LEN_DEF,
  localparam int LP_INDEX_WIDTH = $clog2(P_NUM_ENTRIES)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [P_NUM_PRED-1:0][31:0]               req_pc_i,
  input  logic [P_NUM_PRED-1:0]                     req_valid_i,
  input  logic                                      stall_i,
  input  logic [P_NUM_PRED-1:0]                     br_valid_i,
  input  logic [P_NUM_PRED-1:0]                     br_taken_i,
  input  logic                                      restore_valid_i,
  input  logic [P_HIST_LEN-1:0]                     restore_hist_i,
  output logic [P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0] fw_index_o,
  output logic [P_NUM_PRED-1:0][P_TAG_WIDTH-1:0]    fw_tag_o,
  output logic [P_NUM_PRED-1:0]                     fw_valid_o,
  output logic [P_HIST_LEN-1:0]                     hist_snapshot_o
);

  logic [P_HIST_LEN-1:0] ghr;
  logic [HIST_MAX-1:0]   hash_hist;

  logic [P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0] fw_index_q, fw_index_d;
  logic [P_NUM_PRED-1:0][P_TAG_WIDTH-1:0]    fw_tag_q, fw_tag_d;
  logic [P_NUM_PRED-1:0]                     fw_valid_q;
  logic [P_HIST_LEN-1:0]                     hist_snapshot_q;

  vtage_ghr #(
    .P_NUM_PRED (P_NUM_PRED),
    .P_HIST_LEN (P_HIST_LEN)
  ) u_ghr (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .br_valid_i      (br_valid_i),
    .br_taken_i      (br_taken_i),
    .restore_valid_i (restore_valid_i),
    .restore_hist_i  (restore_hist_i),
    .ghr_o           (ghr)
  );

  // The base bank is PC-only: feeding zero history makes every fold term vanish.
  assign hash_hist = (P_BANK == 0) ? '0 : HIST_MAX'(ghr);

  always_comb begin
    fw_index_d = '0;
    fw_tag_d   = '0;
    for (int s = 0; s < P_NUM_PRED; s++) begin
      fw_index_d[s] = LP_INDEX_WIDTH'(vtage_hash_index(req_pc_i[s], hash_hist,
                                                       P_HIST_LEN, LP_INDEX_WIDTH));
      fw_tag_d[s]   = P_TAG_WIDTH'(vtage_hash_tag(req_pc_i[s], hash_hist, P_HIST_LEN,
                                                  LP_INDEX_WIDTH, P_TAG_WIDTH));
    end
  end

  // Restore flushes even under stall; requests seen during stall are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fw_index_q      <= '0;
      fw_tag_q        <= '0;
      fw_valid_q      <= '0;
      hist_snapshot_q <= '0;
    end else if (restore_valid_i) begin
      fw_valid_q <= '0;
    end else if (!stall_i) begin
      fw_index_q      <= fw_index_d;
      fw_tag_q        <= fw_tag_d;
      fw_valid_q      <= req_valid_i;
      hist_snapshot_q <= ghr;
    end
  end

  assign fw_index_o      = fw_index_q;
  assign fw_tag_o        = fw_tag_q;
  assign fw_valid_o      = fw_valid_q;
  assign hist_snapshot_o = hist_snapshot_q;

endmodule

// File: tb/tb_vtage_index_gen.sv
// Scoreboard bench for vtage_index_gen: bank-1 outputs checked by a monitor
// against hand-computed entries; a bank-0 instance is checked directly.
module tb_vtage_index_gen;

  logic             clk;
  logic             rst;
  logic [1:0][31:0] req_pc;
  logic [1:0]       req_valid;
  logic             stall;
  logic [1:0]       br_valid;
  logic [1:0]       br_taken;
  logic             restore;
  logic [15:0]      rhist;

  logic [1:0][7:0]  fw_index, fw_tag, b0_index, b0_tag;
  logic [1:0]       fw_valid, b0_valid;
  logic [15:0]      snap, b0_snap;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0]  v;
    logic [7:0]  i0, t0, i1, t1;
    logic [15:0] snap;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic upd = 1'b0;

  vtage_index_gen #(.P_BANK(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_pc_i(req_pc), .req_valid_i(req_valid),
    .stall_i(stall), .br_valid_i(br_valid), .br_taken_i(br_taken),
    .restore_valid_i(restore), .restore_hist_i(rhist),
    .fw_index_o(fw_index), .fw_tag_o(fw_tag), .fw_valid_o(fw_valid),
    .hist_snapshot_o(snap)
  );

  vtage_index_gen #(.P_BANK(0)) u_dut_b0 (
    .clk_i(clk), .rst_i(rst), .req_pc_i(req_pc), .req_valid_i(req_valid),
    .stall_i(stall), .br_valid_i(br_valid), .br_taken_i(br_taken),
    .restore_valid_i(restore), .restore_hist_i(rhist),
    .fw_index_o(b0_index), .fw_tag_o(b0_tag), .fw_valid_o(b0_valid),
    .hist_snapshot_o(b0_snap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] v, input logic [7:0] i0, input logic [7:0] t0,
                      input logic [7:0] i1, input logic [7:0] t1, input logic [15:0] s);
    exp_t x;
    x.v = v; x.i0 = i0; x.t0 = t0; x.i1 = i1; x.t1 = t1; x.snap = s;
    sb.push_back(x);
  endtask

  task automatic idle();
    req_pc = '0; req_valid = '0; stall = 1'b0; br_valid = '0; br_taken = '0;
    restore = 1'b0; rhist = '0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // A fresh output appears only after an edge with no reset, restore or stall.
  always @(posedge clk) upd <= !rst && !restore && !stall;

  always @(negedge clk) begin
    if (upd && fw_valid != 2'b00) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got valid=%b, expected no output", fw_valid);
      end else begin
        e = sb.pop_front();
        chk("sb_valid", 32'(fw_valid), 32'(e.v));
        if (e.v[0]) begin
          chk("sb_index0", 32'(fw_index[0]), 32'(e.i0));
          chk("sb_tag0", 32'(fw_tag[0]), 32'(e.t0));
        end
        if (e.v[1]) begin
          chk("sb_index1", 32'(fw_index[1]), 32'(e.i1));
          chk("sb_tag1", 32'(fw_tag[1]), 32'(e.t1));
        end
        chk("sb_snapshot", 32'(snap), 32'(e.snap));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) cyc();
    chk("rst_valid", 32'(fw_valid), 0);
    chk("rst_index0", 32'(fw_index[0]), 0);
    chk("rst_tag0", 32'(fw_tag[0]), 0);
    chk("rst_snapshot", 32'(snap), 0);
    rst = 1'b0;

    // GHR = 0: plain PC hash on both slots
    req_pc[0] = 32'h0000_1234; req_pc[1] = 32'h0000_5678; req_valid = 2'b11;
    push(2'b11, 8'h8D, 8'h04, 8'h9E, 8'h15, 16'h0000);
    cyc(); idle();

    restore = 1'b1; rhist = 16'h00A5;
    cyc(); idle();
    chk("restore_flush_valid", 32'(fw_valid), 0);
    req_pc[0] = 32'h0000_1234; req_valid = 2'b01;
    push(2'b01, 8'h28, 8'hE9, 8'h00, 8'h00, 16'h00A5);
    cyc(); idle();
    chk("b0_index_a5", 32'(b0_index[0]), 32'h8D);
    chk("b0_tag_a5", 32'(b0_tag[0]), 32'h04);
    chk("b0_snapshot_a5", 32'(b0_snap), 32'h00A5);

    // ordered two-slot shift, then request concurrent with a single shift
    restore = 1'b1; rhist = 16'h0001;
    cyc(); idle();
    br_valid = 2'b11; br_taken = 2'b01;
    cyc(); idle();
    br_valid = 2'b10; br_taken = 2'b10;
    req_pc[0] = 32'h0000_1234; req_valid = 2'b01;
    push(2'b01, 8'h8B, 8'h0E, 8'h00, 8'h00, 16'h0006);
    cyc(); idle();
    req_pc[0] = 32'h0000_1234; req_valid = 2'b01;
    push(2'b01, 8'h80, 8'h13, 8'h00, 8'h00, 16'h000D);
    cyc(); idle();

    // restore beats branches and stall
    restore = 1'b1; rhist = 16'h1234; br_valid = 2'b11; br_taken = 2'b11; stall = 1'b1;
    req_pc[0] = 32'h0000_5678; req_valid = 2'b01;
    cyc(); idle();
    chk("flush_over_stall", 32'(fw_valid), 0);
    req_pc[0] = 32'h0000_1234; req_valid = 2'b01;
    push(2'b01, 8'hAB, 8'h02, 8'h00, 8'h00, 16'h1234);
    cyc(); idle();

    // stall holds outputs while GHR keeps shifting
    for (int k = 0; k < 3; k++) begin
      stall = 1'b1; req_pc[0] = 32'h0000_5678; req_valid = 2'b01;
      br_valid = 2'b01; br_taken = 2'b01;
      cyc();
      chk("stall_hold_index", 32'(fw_index[0]), 32'hAB);
      chk("stall_hold_tag", 32'(fw_tag[0]), 32'h02);
      chk("stall_hold_valid", 32'(fw_valid), 32'h1);
      chk("stall_hold_snapshot", 32'(snap), 32'h1234);
    end
    idle();
    req_pc[0] = 32'h0000_5678; req_valid = 2'b01;
    push(2'b01, 8'hA8, 8'h2F, 8'h00, 8'h00, 16'h91A7);
    cyc(); idle();

    // all-ones history: bank 1 folds cancel on the index, bank 0 ignores history
    restore = 1'b1; rhist = 16'hFFFF;
    cyc(); idle();
    req_pc[0] = 32'h0000_1234; req_pc[1] = 32'h0000_5678; req_valid = 2'b11;
    push(2'b11, 8'h8D, 8'h02, 8'h9E, 8'h13, 16'hFFFF);
    cyc(); idle();
    chk("b0_index0_ffff", 32'(b0_index[0]), 32'h8D);
    chk("b0_tag0_ffff", 32'(b0_tag[0]), 32'h04);
    chk("b0_index1_ffff", 32'(b0_index[1]), 32'h9E);
    chk("b0_tag1_ffff", 32'(b0_tag[1]), 32'h15);

    // reset mid-stream wins over stall and restore
    rst = 1'b1; stall = 1'b1; restore = 1'b1; rhist = 16'hBEEF;
    req_pc[0] = 32'h0000_1234; req_valid = 2'b11; br_valid = 2'b11; br_taken = 2'b11;
    cyc(); idle(); rst = 1'b0;
    chk("midrst_valid", 32'(fw_valid), 0);
    chk("midrst_index0", 32'(fw_index[0]), 0);
    chk("midrst_tag0", 32'(fw_tag[0]), 0);
    chk("midrst_snapshot", 32'(snap), 0);
    chk("midrst_b0_valid", 32'(b0_valid), 0);
    chk("midrst_b0_index0", 32'(b0_index[0]), 0);
    req_pc[0] = 32'h0000_1234; req_valid = 2'b01;
    push(2'b01, 8'h8D, 8'h04, 8'h00, 8'h00, 16'h0000);
    cyc(); idle();
    repeat (2) cyc();
    chk("sb_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
